// File: rtl/bcd_seq_pkg.sv
// rtl/bcd_seq_pkg.sv - shared types and helpers for the BCD add sequencer
package bcd_seq_pkg;

    localparam int BCD_DIGIT_W = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } bcd_seq_state_t;

    function automatic logic is_bcd_digit(input logic [3:0] d);
        return d <= 4'd9;
    endfunction

endpackage

// File: rtl/bcd_word_adder.sv
// rtl/bcd_word_adder.sv - combinational multi-digit BCD adder, per-digit ripple with +6 correction
module bcd_word_adder
    import bcd_seq_pkg::*;
#(
    parameter int DIGITS = 4
) (
    input  logic [BCD_DIGIT_W*DIGITS-1:0] a,
    input  logic [BCD_DIGIT_W*DIGITS-1:0] b,
    input  logic                          cin,
    output logic [BCD_DIGIT_W*DIGITS-1:0] sum,
    output logic                          cout,
    output logic                          bad_digit
);

    logic       c;
    logic [4:0] t;

    always_comb begin
        sum       = '0;
        bad_digit = 1'b0;
        c         = cin;
        t         = '0;
        for (int i = 0; i < DIGITS; i++) begin
            t = {1'b0, a[i*BCD_DIGIT_W +: BCD_DIGIT_W]}
              + {1'b0, b[i*BCD_DIGIT_W +: BCD_DIGIT_W]}
              + {4'b0, c};
            // Non-BCD nibbles take the same correction path; the 5-bit wrap keeps the low nibble right.
            if (t > 5'd9) begin
                t = t + 5'd6;
                c = 1'b1;
            end else begin
                c = 1'b0;
            end
            sum[i*BCD_DIGIT_W +: BCD_DIGIT_W] = t[3:0];
            if (!is_bcd_digit(a[i*BCD_DIGIT_W +: BCD_DIGIT_W]) ||
                !is_bcd_digit(b[i*BCD_DIGIT_W +: BCD_DIGIT_W]))
                bad_digit = 1'b1;
        end
        cout = c;
    end

endmodule

// File: rtl/bcd_add_sequencer.sv
// rtl/bcd_add_sequencer.sv - streams a multi-word BCD add, chaining the decimal carry LS word first
module bcd_add_sequencer
    import bcd_seq_pkg::*;
#(
    parameter int DIGITS    = 4,
    parameter int MAX_WORDS = 8,
    parameter int W         = BCD_DIGIT_W * DIGITS,
    parameter int NW        = $clog2(MAX_WORDS + 1)
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          start_i,
    input  logic [NW-1:0] num_words_i,
    input  logic          cin_i,
    input  logic          op_valid_i,
    output logic          op_ready_o,
    input  logic [W-1:0]  a_i,
    input  logic [W-1:0]  b_i,
    output logic          sum_valid_o,
    input  logic          sum_ready_i,
    output logic [W-1:0]  sum_o,
    output logic          sum_last_o,
    output logic          cout_o,
    output logic          busy_o,
    output logic          len_err_o,
    output logic          digit_err_o
);

    bcd_seq_state_t state, state_next;
    logic [NW-1:0]  remaining;
    logic           carry;
    logic [W-1:0]   add_sum;
    logic           add_cout;
    logic           add_bad;
    logic           len_ok;
    logic           accept;
    logic           sum_taken;

    bcd_word_adder #(.DIGITS(DIGITS)) u_adder (
        .a         (a_i),
        .b         (b_i),
        .cin       (carry),
        .sum       (add_sum),
        .cout      (add_cout),
        .bad_digit (add_bad)
    );

    assign len_ok    = (num_words_i != '0) && (num_words_i <= NW'(MAX_WORDS));
    assign accept    = op_valid_i && op_ready_o;
    assign sum_taken = sum_valid_o && sum_ready_i;

    always_comb begin
        state_next = state;
        op_ready_o = 1'b0;
        busy_o     = (state != IDLE);
        case (state)
            IDLE: if (start_i && len_ok) state_next = RUN;
            RUN: begin
                // Single output register: refill in the same cycle the sink drains it.
                op_ready_o = !sum_valid_o || sum_ready_i;
                if (accept && remaining == NW'(1)) state_next = FLUSH;
            end
            FLUSH: if (sum_taken) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state       <= IDLE;
            remaining   <= '0;
            carry       <= 1'b0;
            sum_valid_o <= 1'b0;
            sum_o       <= '0;
            sum_last_o  <= 1'b0;
            cout_o      <= 1'b0;
            len_err_o   <= 1'b0;
            digit_err_o <= 1'b0;
        end else begin
            state     <= state_next;
            len_err_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_i) begin
                        if (len_ok) begin
                            remaining   <= num_words_i;
                            carry       <= cin_i;
                            digit_err_o <= 1'b0;
                        end else begin
                            len_err_o <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (accept) begin
                        sum_o       <= add_sum;
                        sum_valid_o <= 1'b1;
                        carry       <= add_cout;
                        remaining   <= remaining - NW'(1);
                        sum_last_o  <= (remaining == NW'(1));
                        if (remaining == NW'(1)) cout_o <= add_cout;
                        if (add_bad) digit_err_o <= 1'b1;
                    end else if (sum_taken) begin
                        sum_valid_o <= 1'b0;
                    end
                end
                FLUSH: if (sum_taken) sum_valid_o <= 1'b0;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_bcd_add_sequencer.sv
// tb/tb_bcd_add_sequencer.sv - self-checking bench: directed vector table plus randomized multi-word adds
module tb_bcd_add_sequencer;

    localparam int DIGITS    = 4;
    localparam int MAX_WORDS = 8;
    localparam int W         = 16;
    localparam int NW        = 4;

    logic          clk_i = 1'b0;
    logic          rst_i = 1'b1;
    logic          start_i = 1'b0;
    logic [NW-1:0] num_words_i = '0;
    logic          cin_i = 1'b0;
    logic          op_valid_i = 1'b0;
    logic          op_ready_o;
    logic [W-1:0]  a_i = '0;
    logic [W-1:0]  b_i = '0;
    logic          sum_valid_o;
    logic          sum_ready_i = 1'b0;
    logic [W-1:0]  sum_o;
    logic          sum_last_o;
    logic          cout_o;
    logic          busy_o;
    logic          len_err_o;
    logic          digit_err_o;

    bcd_add_sequencer #(.DIGITS(DIGITS), .MAX_WORDS(MAX_WORDS)) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .start_i     (start_i),
        .num_words_i (num_words_i),
        .cin_i       (cin_i),
        .op_valid_i  (op_valid_i),
        .op_ready_o  (op_ready_o),
        .a_i         (a_i),
        .b_i         (b_i),
        .sum_valid_o (sum_valid_o),
        .sum_ready_i (sum_ready_i),
        .sum_o       (sum_o),
        .sum_last_o  (sum_last_o),
        .cout_o      (cout_o),
        .busy_o      (busy_o),
        .len_err_o   (len_err_o),
        .digit_err_o (digit_err_o)
    );

    always #5 clk_i = ~clk_i;

    int pass_cnt = 0;
    int total_cnt = 0;

    logic [W-1:0] op_a [8];
    logic [W-1:0] op_b [8];
    logic [W-1:0] ex_s [8];
    logic         ex_cout;
    logic         ex_derr;

    typedef struct packed {
        logic [3:0]        n;
        logic              cin;
        logic [7:0][15:0]  a;
        logic [7:0][15:0]  b;
        logic [7:0][15:0]  s;
        logic              cout;
        logic              derr;
        logic [1:0]        mode;
    } vec_t;

    vec_t tbl [5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    function automatic logic all_bcd(input logic [W-1:0] w);
        for (int d = 0; d < DIGITS; d++)
            if (w[4*d +: 4] > 4'd9) return 1'b0;
        return 1'b1;
    endfunction

    function automatic int bcd_val(input logic [W-1:0] w);
        int v = 0;
        for (int d = DIGITS - 1; d >= 0; d--) v = v * 10 + int'(w[4*d +: 4]);
        return v;
    endfunction

    function automatic logic [W-1:0] to_bcd(input int v);
        logic [W-1:0] r = '0;
        for (int d = 0; d < DIGITS; d++) begin
            r[4*d +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return r;
    endfunction

    // Decimal arithmetic for legal operands; the digit-wise binary+6 rule only for illegal nibbles.
    task automatic word_add(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci,
                            output logic [W-1:0] s, output logic co);
        if (all_bcd(a) && all_bcd(b)) begin
            int v = bcd_val(a) + bcd_val(b) + int'(ci);
            co = (v >= 10000);
            s  = to_bcd(v % 10000);
        end else begin
            int c = int'(ci);
            s = '0;
            for (int d = 0; d < DIGITS; d++) begin
                int t = int'(a[4*d +: 4]) + int'(b[4*d +: 4]) + c;
                if (t > 9) begin
                    s[4*d +: 4] = 4'((t + 6) % 16);
                    c = 1;
                end else begin
                    s[4*d +: 4] = 4'(t);
                    c = 0;
                end
            end
            co = (c != 0);
        end
    endtask

    task automatic model_op(input int n, input logic ci);
        logic c = ci;
        logic [W-1:0] s;
        logic co;
        ex_derr = 1'b0;
        for (int i = 0; i < n; i++) begin
            word_add(op_a[i], op_b[i], c, s, co);
            ex_s[i] = s;
            c = co;
            if (!all_bcd(op_a[i]) || !all_bcd(op_b[i])) ex_derr = 1'b1;
        end
        ex_cout = c;
    endtask

    task automatic do_start(input int n, input logic ci, input bit ok);
        start_i = 1'b1;
        num_words_i = NW'(n);
        cin_i = ci;
        @(posedge clk_i); #1;
        start_i = 1'b0;
        if (ok) begin
            chk("start_busy", 32'(busy_o), 32'd1);
            chk("start_op_ready", 32'(op_ready_o), 32'd1);
        end else begin
            chk("len_err_pulse", 32'(len_err_o), 32'd1);
            chk("len_err_busy", 32'(busy_o), 32'd0);
            @(posedge clk_i); #1;
            chk("len_err_once", 32'(len_err_o), 32'd0);
            chk("len_err_idle", 32'(busy_o), 32'd0);
        end
    endtask

    // ready_mode: 0 sink always ready, 1 random, 2 stall 4 cycles after the first beat
    task automatic run_op(input int n, input int ready_mode, input bit rand_valid);
        int widx = 0, ridx = 0, cyc = 0, stall_cnt = 0;
        logic in_hs, out_hs, prev_stall = 1'b0, stray = 1'b0;
        logic [W-1:0] prev_sum = '0;
        logic prev_last = 1'b0, prev_cout = 1'b0;
        while (ridx < n) begin
            if (cyc >= 300) begin
                chk("op_timeout", 32'(ridx), 32'(n));
                break;
            end
            op_valid_i = (widx < n) && (!rand_valid || $urandom_range(0, 3) != 0);
            if (widx < n) begin
                a_i = op_a[widx];
                b_i = op_b[widx];
            end else begin
                a_i = '0;
                b_i = '0;
            end
            case (ready_mode)
                0: sum_ready_i = 1'b1;
                1: sum_ready_i = ($urandom_range(0, 2) != 0);
                default: begin
                    if (ridx >= 1 && stall_cnt < 4) begin
                        sum_ready_i = 1'b0;
                        stall_cnt++;
                    end else sum_ready_i = 1'b1;
                end
            endcase
            start_i = 1'($urandom_range(0, 1));
            num_words_i = '0;
            @(negedge clk_i);
            if (len_err_o) stray = 1'b1;
            if (prev_stall) begin
                chk("hold_sum", 32'(sum_o), 32'(prev_sum));
                chk("hold_last", 32'(sum_last_o), 32'(prev_last));
                chk("hold_cout", 32'(cout_o), 32'(prev_cout));
            end
            in_hs  = op_valid_i & op_ready_o;
            out_hs = sum_valid_o & sum_ready_i;
            if (sum_valid_o && !sum_ready_i) begin
                chk("stall_op_ready", 32'(op_ready_o), 32'd0);
                prev_stall = 1'b1;
                prev_sum   = sum_o;
                prev_last  = sum_last_o;
                prev_cout  = cout_o;
            end else prev_stall = 1'b0;
            if (out_hs) begin
                chk("sum_word", 32'(sum_o), 32'(ex_s[ridx]));
                chk("sum_last", 32'(sum_last_o), 32'(ridx == n - 1));
                if (ridx == n - 1) chk("cout", 32'(cout_o), 32'(ex_cout));
                ridx++;
            end
            @(posedge clk_i); #1;
            cyc++;
            if (in_hs) widx++;
        end
        start_i = 1'b0;
        op_valid_i = 1'b0;
        chk("busy_after", 32'(busy_o), 32'd0);
        chk("valid_after", 32'(sum_valid_o), 32'd0);
        chk("words_consumed", 32'(widx), 32'(n));
        chk("digit_err", 32'(digit_err_o), 32'(ex_derr));
        chk("start_ignored", 32'(stray), 32'd0);
    endtask

    task automatic load_vec(input vec_t v);
        for (int j = 0; j < 8; j++) begin
            op_a[j] = v.a[j];
            op_b[j] = v.b[j];
            ex_s[j] = v.s[j];
        end
        ex_cout = v.cout;
        ex_derr = v.derr;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 5; i++) tbl[i] = '0;
        tbl[0].n = 1; tbl[0].a[0] = 16'h0999; tbl[0].b[0] = 16'h0001; tbl[0].s[0] = 16'h1000;
        tbl[1].n = 2; tbl[1].a[0] = 16'h9999; tbl[1].b[0] = 16'h0001; tbl[1].s[0] = 16'h0000;
        tbl[1].a[1] = 16'h9999; tbl[1].b[1] = 16'h0000; tbl[1].s[1] = 16'h0000; tbl[1].cout = 1'b1;
        tbl[2].n = 3; tbl[2].mode = 2'd2;
        tbl[2].a[0] = 16'h5000; tbl[2].b[0] = 16'h5000; tbl[2].s[0] = 16'h0000;
        tbl[2].a[1] = 16'h0000; tbl[2].b[1] = 16'h0000; tbl[2].s[1] = 16'h0001;
        tbl[2].a[2] = 16'h9999; tbl[2].b[2] = 16'h0001; tbl[2].s[2] = 16'h0000; tbl[2].cout = 1'b1;
        tbl[3].n = 1; tbl[3].cin = 1'b1; tbl[3].a[0] = 16'h1234; tbl[3].b[0] = 16'h8765;
        tbl[3].s[0] = 16'h0000; tbl[3].cout = 1'b1;
        tbl[4].n = 1; tbl[4].a[0] = 16'h000A; tbl[4].b[0] = 16'h0000; tbl[4].s[0] = 16'h0010;
        tbl[4].derr = 1'b1;

        rst_i = 1'b1;
        repeat (3) @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        chk("reset_outputs",
            32'({op_ready_o, sum_valid_o, sum_o, sum_last_o, cout_o, busy_o, len_err_o, digit_err_o}), 32'd0);

        for (int i = 0; i < 5; i++) begin
            load_vec(tbl[i]);
            do_start(int'(tbl[i].n), tbl[i].cin, 1'b1);
            run_op(int'(tbl[i].n), int'(tbl[i].mode), 1'b0);
        end

        do_start(0, 1'b0, 1'b0);
        do_start(MAX_WORDS + 1, 1'b0, 1'b0);
        chk("digit_err_sticky", 32'(digit_err_o), 32'd1);

        op_a[0] = 16'h0001; op_b[0] = 16'h0002;
        model_op(1, 1'b0);
        do_start(1, 1'b0, 1'b1);
        chk("digit_err_cleared", 32'(digit_err_o), 32'd0);
        run_op(1, 0, 1'b0);

        do_start(4, 1'b0, 1'b1);
        op_valid_i = 1'b1; a_i = 16'h000B; b_i = 16'h0000; sum_ready_i = 1'b0;
        @(posedge clk_i); #1;
        op_valid_i = 1'b0;
        chk("pre_reset_valid", 32'(sum_valid_o), 32'd1);
        chk("pre_reset_derr", 32'(digit_err_o), 32'd1);
        rst_i = 1'b1;
        @(posedge clk_i); #1;
        rst_i = 1'b0;
        chk("midop_reset_outputs",
            32'({op_ready_o, sum_valid_o, sum_o, sum_last_o, cout_o, busy_o, len_err_o, digit_err_o}), 32'd0);
        op_a[0] = 16'h0456; op_b[0] = 16'h0544;
        model_op(1, 1'b0);
        chk("model_post_reset", 32'(ex_s[0]), 32'h1000);
        do_start(1, 1'b0, 1'b1);
        run_op(1, 0, 1'b0);

        for (int r = 0; r < 25; r++) begin
            int n = $urandom_range(1, MAX_WORDS);
            logic ci = 1'($urandom_range(0, 1));
            for (int j = 0; j < n; j++) begin
                for (int d = 0; d < DIGITS; d++) begin
                    op_a[j][4*d +: 4] = 4'($urandom_range(0, 9));
                    op_b[j][4*d +: 4] = 4'($urandom_range(0, 9));
                end
                if ($urandom_range(0, 9) == 0) op_a[j][4*$urandom_range(0, 3) +: 4] = 4'($urandom_range(10, 15));
            end
            model_op(n, ci);
            do_start(n, ci, 1'b1);
            run_op(n, 1, 1'b1);
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
